// File: rtl/tblink_rpc_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tblink_rpc_pkt_arb
// Purpose  : Packet-level round-robin arbiter. Shares one 8-bit ready/valid
//            byte stream (the endpoint tipi input) among NUM_REQ sources. Each
//            packet is a length byte L followed by L payload bytes. The grant
//            is held from the length byte through the last payload byte, so
//            packets are never interleaved.
// Ports    : uclock     - clock
//            reset_n    - asynchronous active-low reset
//            req_dat    - requester bytes, requester i at [i*8+7:i*8]
//            req_valid  - per-requester valid
//            req_ready  - per-requester ready (only the owner's can be set)
//            out_dat    - arbitrated byte stream to the endpoint
//            out_valid  - output valid
//            out_ready  - output ready from the endpoint
//            grant      - one-hot current owner, 0 when idle
//            busy       - packet in progress
// Options  : TBLINK_RPC_PKT_ARB_SRCTAG_EN - when defined, a source tag byte
//            {zeros, owner index} is inserted after the length byte.
// Revision : 1.0 - initial release
// ============================================================================
module tblink_rpc_pkt_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 uclock,
  input  logic                 reset_n,
  input  logic [NUM_REQ*8-1:0] req_dat,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_dat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    TAG  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_q,  last_d;
  logic [7:0]           remaining_q, remaining_d;

  logic [IDX_W-1:0]     w_cand;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_found;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [7:0]           w_own_dat;
  logic                 w_own_valid;
  logic                 w_fire;

  // Round-robin pick: first valid requester scanning last+1, last+2, ...
  // The previous owner is visited last, giving it lowest priority.
  always_comb begin
    w_cand  = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
    w_sel_oh = NUM_REQ'(1) << w_sel;
  end

  // Owner data/valid mux; grant is one-hot while a packet is in flight.
  always_comb begin
    w_own_dat   = '0;
    w_own_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        w_own_dat   = req_dat[i*8 +: 8];
        w_own_valid = req_valid[i];
      end
    end
  end

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    out_dat     = '0;
    out_valid   = 1'b0;
    req_ready   = '0;
    w_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        // One-cycle arbitration bubble; no data moves here.
        if (|req_valid) begin
          grant_d = w_sel_oh;
          last_d  = w_sel;
          state_d = HDR;
        end
      end

      HDR: begin
        out_dat   = w_own_dat;
        out_valid = w_own_valid;
        req_ready = grant_q & {NUM_REQ{out_ready}};
        w_fire    = w_own_valid & out_ready;
        if (w_fire) begin
          remaining_d = w_own_dat;
`ifdef TBLINK_RPC_PKT_ARB_SRCTAG_EN
          state_d = TAG;
`else
          if (w_own_dat == 8'd0) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            state_d = BODY;
          end
`endif
        end
      end

`ifdef TBLINK_RPC_PKT_ARB_SRCTAG_EN
      TAG: begin
        // Arbiter-generated byte: no source is consumed.
        out_dat   = {{(8-IDX_W){1'b0}}, last_q};
        out_valid = 1'b1;
        if (out_ready) begin
          if (remaining_q != 8'd0) begin
            state_d = BODY;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
`endif

      BODY: begin
        out_dat   = w_own_dat;
        out_valid = w_own_valid;
        req_ready = grant_q & {NUM_REQ{out_ready}};
        w_fire    = w_own_valid & out_ready;
        if (w_fire) begin
          // Saturate at zero; a zero count in BODY is treated as packet end.
          remaining_d = (remaining_q != 8'd0) ? (remaining_q - 8'd1) : 8'd0;
          if (remaining_q <= 8'd1) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tblink_rpc_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tblink_rpc_pkt_arb
// Purpose  : Scoreboard bench for tblink_rpc_pkt_arb. Directed packets are
//            queued per source; expected output bytes (with owner) are queued
//            in hand-derived order; a monitor compares every transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tblink_rpc_pkt_arb;

  localparam int N = 4;

  logic           uclock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*8-1:0] req_dat;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [7:0]     out_dat;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;

  tblink_rpc_pkt_arb #(.NUM_REQ(N)) u_dut (
    .uclock    (uclock),
    .reset_n   (reset_n),
    .req_dat   (req_dat),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_dat   (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 uclock = ~uclock;

  typedef struct packed {
    logic       tag;
    logic [1:0] owner;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] srcq[N][$];
  logic [N-1:0] fire = '0;
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  xfer_cnt = 0;
  bit  rdy_mode = 1'b0;
  int  pat      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic src_pkt(input int r, input int len, input logic [7:0] base);
    srcq[r].push_back(8'(len));
    for (int k = 0; k < len; k++) srcq[r].push_back(base + 8'(k));
  endtask

  task automatic exp_pkt(input int r, input int len, input logic [7:0] base);
    exp_t e;
    e.tag = 1'b0; e.owner = 2'(r); e.dat = 8'(len);
    sb.push_back(e);
`ifdef TBLINK_RPC_PKT_ARB_SRCTAG_EN
    e.tag = 1'b1; e.dat = 8'(r);
    sb.push_back(e);
    e.tag = 1'b0;
`endif
    for (int k = 0; k < len; k++) begin
      e.dat = base + 8'(k);
      sb.push_back(e);
    end
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int i = 0; i < N; i++) srcq[i].delete();
    sb.delete();
  endtask

  // Wait for all queued traffic to drain, then the arbiter must be idle.
  task automatic wait_idle(input string name);
    int cyc = 0;
    while ((sb.size() != 0 || src_busy()) && cyc < 500) begin
      @(negedge uclock); #1;
      cyc++;
    end
    chk({name, "_drain"}, 32'(cyc < 500), 32'd1);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    chk({name, "_grant_idle"}, 32'(grant), 32'd0);
    chk({name, "_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge uclock); #1;
    reset_n = 1'b0;
    flush();
    repeat (2) @(negedge uclock);
    reset_n = 1'b1;
  endtask

  // Source driver: pop bytes that transferred on the previous edge, then
  // present the next byte of each source queue.
  initial begin
    req_valid = '0;
    req_dat   = '0;
    out_ready = 1'b1;
    forever begin
      @(posedge uclock); #1;
      for (int i = 0; i < N; i++)
        if (fire[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (srcq[i].size() != 0);
        req_dat[i*8 +: 8] = (srcq[i].size() != 0) ? srcq[i][0] : 8'h00;
      end
      if (rdy_mode) begin
        out_ready = ((pat % 3) == 0);
        pat++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: compares each offered/transferred byte against the scoreboard.
  always @(negedge uclock) begin
    exp_t       e;
    logic [N-1:0] oh;
    logic [N-1:0] er;
    if (!reset_n) begin
      fire = '0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got out_dat=%02h grant=%b, expected no output", out_dat, grant);
        end else begin
          e  = sb[0];
          oh = N'(1) << e.owner;
          er = (out_ready && !e.tag) ? oh : '0;
          chk("req_ready", 32'(req_ready), 32'(er));
          if (out_ready) begin
            chk("out_dat", 32'(out_dat), 32'(e.dat));
            chk("grant", 32'(grant), 32'(oh));
            void'(sb.pop_front());
            xfer_cnt++;
          end
        end
      end
      fire = req_valid & req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    // Reset state
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_dat", 32'(out_dat), 32'd0);
    #20;
    @(negedge uclock);
    reset_n = 1'b1;

    // T1: req1 sends {3,A1,A2,A3}
    @(negedge uclock); #1;
    src_pkt(1, 3, 8'hA1);
    exp_pkt(1, 3, 8'hA1);
    @(posedge uclock); #2;
    @(posedge uclock);
    @(negedge uclock);
    chk("t1_grant_after_valid", 32'(grant), 32'b0010);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1");

    // T2: req0 and req2 together; req0 first after reset
    do_reset();
    @(negedge uclock); #1;
    src_pkt(0, 2, 8'h10);
    src_pkt(2, 2, 8'h20);
    exp_pkt(0, 2, 8'h10);
    exp_pkt(2, 2, 8'h20);
    wait_idle("t2");

    // T3: all requesters continuously valid, two 1-byte packets each
    do_reset();
    @(negedge uclock); #1;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++)
        src_pkt(r, 1, 8'(8'h30 + 8'(p*16 + r)));
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++)
        exp_pkt(r, 1, 8'(8'h30 + 8'(p*16 + r)));
    wait_idle("t3");

    // T4: req3 zero-length packet
    @(negedge uclock); #1;
    src_pkt(3, 0, 8'h00);
    exp_pkt(3, 0, 8'h00);
    wait_idle("t4");

    // T5: req0 {4,...} with out_ready pattern 1,0,0,...
    @(negedge uclock); #1;
    rdy_mode = 1'b1;
    pat = 0;
    src_pkt(0, 4, 8'hC0);
    exp_pkt(0, 4, 8'hC0);
    wait_idle("t5");
    rdy_mode = 1'b0;

    // T6: reset after 2 of 5 bytes, then req2 sends {1,55}
    @(negedge uclock); #1;
    base = xfer_cnt;
    src_pkt(0, 4, 8'hD0);
    exp_pkt(0, 4, 8'hD0);
    cyc = 0;
    while (xfer_cnt < base + 2 && cyc < 200) begin
      @(negedge uclock); #1;
      cyc++;
    end
    chk("t6_two_bytes", 32'(cyc < 200), 32'd1);
    @(posedge uclock); #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_out_dat", 32'(out_dat), 32'd0);
    flush();
    repeat (2) @(negedge uclock);
    reset_n = 1'b1;
    @(negedge uclock); #1;
    src_pkt(2, 1, 8'h55);
    exp_pkt(2, 1, 8'h55);
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
